// File: rtl/open_loop_flow_sched_if.sv
// Bundle of setup, notification, request and completion signals around the open-loop
// flow scheduler; slave is the scheduler side, master the surrounding decoders/datapath.
interface open_loop_flow_sched_if #(
   parameter int unsigned NUM_FLOWS = 8,
   parameter int unsigned PTR_W     = 16
);
   localparam int unsigned FLOW_W = $clog2(NUM_FLOWS);

   logic                 setup_val;
   logic [FLOW_W-1:0]    setup_flowid;
   logic [31:0]          setup_total;
   logic [31:0]          setup_bufsize;
   logic [7:0]           setup_dir;
   logic                 setup_rdy;

   logic                 notif_val;
   logic [FLOW_W-1:0]    notif_flowid;
   logic [PTR_W-1:0]     notif_ptr;
   logic [PTR_W-1:0]     notif_len;
   logic                 notif_rdy;

   logic                 req_val;
   logic [FLOW_W-1:0]    req_flowid;
   logic [PTR_W-1:0]     req_ptr;
   logic [PTR_W-1:0]     req_len;
   logic [7:0]           req_dir;
   logic                 req_rdy;

   logic                 done_val;
   logic [FLOW_W-1:0]    done_flowid;

   logic                 flow_done;
   logic [FLOW_W-1:0]    flow_done_id;
   logic [NUM_FLOWS-1:0] flow_active;

   modport slave (
      input  setup_val, setup_flowid, setup_total, setup_bufsize, setup_dir,
      output setup_rdy,
      input  notif_val, notif_flowid, notif_ptr, notif_len,
      output notif_rdy,
      output req_val, req_flowid, req_ptr, req_len, req_dir,
      input  req_rdy,
      input  done_val, done_flowid,
      output flow_done, flow_done_id, flow_active
   );

   modport master (
      output setup_val, setup_flowid, setup_total, setup_bufsize, setup_dir,
      input  setup_rdy,
      output notif_val, notif_flowid, notif_ptr, notif_len,
      input  notif_rdy,
      input  req_val, req_flowid, req_ptr, req_len, req_dir,
      output req_rdy,
      output done_val, done_flowid,
      input  flow_done, flow_done_id, flow_active
   );
endinterface

// File: rtl/open_loop_flow_sched.sv
// Per-flow scheduler: keeps flow context, latches notifications and issues at most one
// outstanding datapath request per flow, round-robin among eligible flows.
module open_loop_flow_sched #(
   parameter int unsigned NUM_FLOWS = 8,
   parameter int unsigned PTR_W     = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   open_loop_flow_sched_if.slave bus
);
   localparam int unsigned FLOW_W = $clog2(NUM_FLOWS);

   typedef logic [FLOW_W-1:0] flow_t;
   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e               state_q, state_d;
   logic [31:0]          total_q   [NUM_FLOWS];
   logic [31:0]          total_d   [NUM_FLOWS];
   logic [31:0]          bufsize_q [NUM_FLOWS];
   logic [31:0]          bufsize_d [NUM_FLOWS];
   logic [31:0]          curr_q    [NUM_FLOWS];
   logic [31:0]          curr_d    [NUM_FLOWS];
   logic [7:0]           dir_q     [NUM_FLOWS];
   logic [7:0]           dir_d     [NUM_FLOWS];
   logic [PTR_W-1:0]     ptr_q     [NUM_FLOWS];
   logic [PTR_W-1:0]     ptr_d     [NUM_FLOWS];
   logic [PTR_W-1:0]     len_q     [NUM_FLOWS];
   logic [PTR_W-1:0]     len_d     [NUM_FLOWS];
   logic [NUM_FLOWS-1:0] active_q, active_d;
   logic [NUM_FLOWS-1:0] pending_q, pending_d;
   logic [NUM_FLOWS-1:0] inflight_q, inflight_d;
   flow_t                rr_ptr_q, rr_ptr_d;
   flow_t                grant_q, grant_d;
   logic [PTR_W-1:0]     req_ptr_q, req_ptr_d;
   logic [PTR_W-1:0]     req_len_q, req_len_d;
   logic [7:0]           req_dir_q, req_dir_d;
   logic                 flow_done_q, flow_done_d;
   flow_t                flow_done_id_q, flow_done_id_d;

   logic [NUM_FLOWS-1:0] eligible;
   logic                 pick_val;
   flow_t                pick;
   flow_t                idx;
   logic [31:0]          pick_len_ext;
   logic                 setup_conflict;
   logic                 setup_acc;
   logic                 notif_acc;
   logic                 done_hit;
   logic [31:0]          done_next;

   assign eligible = active_q & pending_q & ~inflight_q;

   // First eligible flow at or after rr_ptr; flow_t arithmetic wraps mod NUM_FLOWS.
   always_comb begin
      pick_val = 1'b0;
      pick     = '0;
      idx      = '0;
      for (int unsigned i = 0; i < NUM_FLOWS; i++) begin
         idx = rr_ptr_q + flow_t'(i);
         if (!pick_val && eligible[idx]) begin
            pick_val = 1'b1;
            pick     = idx;
         end
      end
   end

   assign pick_len_ext = 32'(len_q[pick]);

   assign setup_conflict = bus.setup_val && (bus.setup_flowid == bus.notif_flowid);
   assign bus.setup_rdy  = !inflight_q[bus.setup_flowid];
   // Inactive flows accept and drop notifications so the NoC decoder never stalls on them.
   assign bus.notif_rdy  = !setup_conflict &&
                           (!active_q[bus.notif_flowid] || !pending_q[bus.notif_flowid]);
   assign setup_acc      = bus.setup_val && bus.setup_rdy;
   assign notif_acc      = bus.notif_val && bus.notif_rdy && active_q[bus.notif_flowid];
   assign done_hit       = bus.done_val && inflight_q[bus.done_flowid];
   assign done_next      = curr_q[bus.done_flowid] + 32'd1;

   always_comb begin
      state_d        = state_q;
      total_d        = total_q;
      bufsize_d      = bufsize_q;
      curr_d         = curr_q;
      dir_d          = dir_q;
      ptr_d          = ptr_q;
      len_d          = len_q;
      active_d       = active_q;
      pending_d      = pending_q;
      inflight_d     = inflight_q;
      rr_ptr_d       = rr_ptr_q;
      grant_d        = grant_q;
      req_ptr_d      = req_ptr_q;
      req_len_d      = req_len_q;
      req_dir_d      = req_dir_q;
      flow_done_d    = 1'b0;
      flow_done_id_d = '0;

      unique case (state_q)
         StIdle: begin
            if (pick_val) begin
               grant_d   = pick;
               req_ptr_d = ptr_q[pick];
               req_len_d = (pick_len_ext < bufsize_q[pick]) ? len_q[pick]
                                                            : bufsize_q[pick][PTR_W-1:0];
               req_dir_d = dir_q[pick];
               state_d   = StIssue;
            end
         end
         StIssue: begin
            if (bus.req_rdy) begin
               pending_d[grant_q]  = 1'b0;
               inflight_d[grant_q] = 1'b1;
               rr_ptr_d            = grant_q + flow_t'(1);
               state_d             = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (notif_acc) begin
         ptr_d[bus.notif_flowid]     = bus.notif_ptr;
         len_d[bus.notif_flowid]     = bus.notif_len;
         pending_d[bus.notif_flowid] = 1'b1;
      end

      if (done_hit) begin
         inflight_d[bus.done_flowid] = 1'b0;
         curr_d[bus.done_flowid]     = done_next;
         if (done_next == total_q[bus.done_flowid]) begin
            active_d[bus.done_flowid]  = 1'b0;
            pending_d[bus.done_flowid] = 1'b0;
            flow_done_d                = 1'b1;
            flow_done_id_d             = bus.done_flowid;
         end
      end

      if (setup_acc) begin
         total_d[bus.setup_flowid]   = bus.setup_total;
         bufsize_d[bus.setup_flowid] = bus.setup_bufsize;
         dir_d[bus.setup_flowid]     = bus.setup_dir;
         curr_d[bus.setup_flowid]    = '0;
         pending_d[bus.setup_flowid] = 1'b0;
         active_d[bus.setup_flowid]  = (bus.setup_total != 32'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         total_q        <= '{default: '0};
         bufsize_q      <= '{default: '0};
         curr_q         <= '{default: '0};
         dir_q          <= '{default: '0};
         ptr_q          <= '{default: '0};
         len_q          <= '{default: '0};
         active_q       <= '0;
         pending_q      <= '0;
         inflight_q     <= '0;
         rr_ptr_q       <= '0;
         grant_q        <= '0;
         req_ptr_q      <= '0;
         req_len_q      <= '0;
         req_dir_q      <= '0;
         flow_done_q    <= 1'b0;
         flow_done_id_q <= '0;
      end else begin
         state_q        <= state_d;
         total_q        <= total_d;
         bufsize_q      <= bufsize_d;
         curr_q         <= curr_d;
         dir_q          <= dir_d;
         ptr_q          <= ptr_d;
         len_q          <= len_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         inflight_q     <= inflight_d;
         rr_ptr_q       <= rr_ptr_d;
         grant_q        <= grant_d;
         req_ptr_q      <= req_ptr_d;
         req_len_q      <= req_len_d;
         req_dir_q      <= req_dir_d;
         flow_done_q    <= flow_done_d;
         flow_done_id_q <= flow_done_id_d;
      end
   end

   assign bus.req_val      = (state_q == StIssue);
   assign bus.req_flowid   = grant_q;
   assign bus.req_ptr      = req_ptr_q;
   assign bus.req_len      = req_len_q;
   assign bus.req_dir      = req_dir_q;
   assign bus.flow_done    = flow_done_q;
   assign bus.flow_done_id = flow_done_id_q;
   assign bus.flow_active  = active_q;
endmodule
